hdmi_packet_scheduler: RTL and testbench

- Sits directly downstream of the audio clock regeneration (ACR) packet generator and upstream of the data-island packet assembler.
- Consumes the ACR toggle output, buffers incoming stereo audio samples and tracks infoframe due-flags.
- On each data-island packet slot it decides which packet type is sent next, and registers the audio payload and IEC 60958 block-start flags.

---
 rtl/hdmi_packet_scheduler.sv | 247 ++++++++++++++++++++++++
 tb/tb_hdmi_packet_scheduler.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hdmi_packet_scheduler.sv
// hdmi_packet_scheduler
//
// Purpose:
//   Picks the packet type for each data-island packet slot and registers the
//   audio payload that goes with it. The block sits between the ACR packet
//   generator and the data-island packet assembler. It keeps three request
//   flags (ACR, AVI infoframe, audio infoframe) and a small FIFO of stereo
//   audio samples, each tagged with its IEC 60958 block-start (B) bit.
//
//   Selection priority on packet_enable:
//     ACR > audio (FIFO not empty) > AVI > AIF > null
//
// Ports:
//   clk_pixel              in   1   pixel clock, the only clock
//   reset                  in   1   synchronous, active-high reset
//   clk_audio_counter_wrap in   1   ACR toggle; every level change requests ACR
//   frame_start            in   1   frame pulse; requests AVI and AIF
//   audio_sample_valid     in   1   audio_sample_word is valid this cycle
//   audio_sample_word      in  32   [15:0] left, [31:16] right
//   packet_enable          in   1   start of a 32-cycle packet slot
//   packet_type            out  8   0x00 null, 0x01 ACR, 0x02 audio,
//                                   0x82 AVI infoframe, 0x84 audio infoframe
//   audio_samples          out 128  slot k in bits [32k+31:32k]
//   audio_sample_present   out  4   bit k set when slot k holds a sample
//   audio_sample_b         out  4   bit k set when slot k starts an IEC block
//   audio_overflow         out  1   sticky, a sample was dropped (FIFO full)
//   stat_acr_count         out 16   ACR packets issued (stats build only)
//   stat_audio_count       out 16   audio packets issued (stats build only)
//
// Build option:
//   HDMI_PACKET_SCHED_STATS_EN - when defined, the two saturating packet
//   counters are built; otherwise both stat ports are tied to zero.

module hdmi_packet_scheduler #(
  parameter int AUDIO_FIFO_DEPTH = 4,
  parameter int IEC_BLOCK_LEN    = 192
) (
  input  logic         clk_pixel,
  input  logic         reset,
  input  logic         clk_audio_counter_wrap,
  input  logic         frame_start,
  input  logic         audio_sample_valid,
  input  logic [31:0]  audio_sample_word,
  input  logic         packet_enable,
  output logic [7:0]   packet_type,
  output logic [127:0] audio_samples,
  output logic [3:0]   audio_sample_present,
  output logic [3:0]   audio_sample_b,
  output logic         audio_overflow,
  output logic [15:0]  stat_acr_count,
  output logic [15:0]  stat_audio_count
);

  localparam int PW = $clog2(AUDIO_FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int IW = (IEC_BLOCK_LEN > 1) ? $clog2(IEC_BLOCK_LEN) : 1;

  localparam logic [CW-1:0] DEPTH_C  = CW'(AUDIO_FIFO_DEPTH);
  localparam logic [CW-1:0] SLOTS_C  = CW'(4);
  localparam logic [IW-1:0] IEC_LAST = IW'(IEC_BLOCK_LEN - 1);

  typedef enum logic [7:0] {
    PT_NULL  = 8'h00,
    PT_ACR   = 8'h01,
    PT_AUDIO = 8'h02,
    PT_AVI   = 8'h82,
    PT_AIF   = 8'h84
  } pkt_t;

  // Request tracking
  logic wrap_hist_q;
  logic acr_pending_q, acr_pending_d;
  logic avi_pending_q, avi_pending_d;
  logic aif_pending_q, aif_pending_d;
  logic acr_toggle;

  // Sample FIFO
  logic [31:0]   fifo_word_q [AUDIO_FIFO_DEPTH];
  logic          fifo_b_q    [AUDIO_FIFO_DEPTH];
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [CW-1:0] count_after_pop;
  logic [CW-1:0] pop_n;
  logic          push_ok;
  logic          push_b;
  logic [IW-1:0] iec_cnt_q, iec_cnt_d;
  logic          overflow_q, overflow_d;

  // Slot decision and registered payload
  pkt_t          sel;
  pkt_t          pkt_type_q, pkt_type_d;
  logic [127:0]  samples_q, samples_d;
  logic [3:0]    present_q, present_d;
  logic [3:0]    b_q, b_d;
  logic [PW-1:0] rd_idx;

  assign acr_toggle = clk_audio_counter_wrap ^ wrap_hist_q;

  // Priority decision uses only already-registered requests, so a request
  // raised in the same cycle as packet_enable waits for the next slot.
  always_comb begin
    sel = PT_NULL;
    if (acr_pending_q) begin
      sel = PT_ACR;
    end else if (count_q != '0) begin
      sel = PT_AUDIO;
    end else if (avi_pending_q) begin
      sel = PT_AVI;
    end else if (aif_pending_q) begin
      sel = PT_AIF;
    end
  end

  always_comb begin
    acr_pending_d = (acr_pending_q & ~(packet_enable & (sel == PT_ACR))) | acr_toggle;
    avi_pending_d = (avi_pending_q & ~(packet_enable & (sel == PT_AVI))) | frame_start;
    aif_pending_d = (aif_pending_q & ~(packet_enable & (sel == PT_AIF))) | frame_start;
  end

  // audio_sample_valid has no back-pressure: a sample is accepted when the
  // FIFO has room after this cycle's pop, otherwise it is dropped and the
  // sticky overflow flag is raised. Pop is applied before push, so a push
  // in the same cycle as an audio pop of n >= 1 entries always fits.
  always_comb begin
    pop_n = '0;
    if (packet_enable && (sel == PT_AUDIO)) begin
      pop_n = (count_q >= SLOTS_C) ? SLOTS_C : count_q;
    end
    count_after_pop = count_q - pop_n;
    push_ok         = audio_sample_valid && (count_after_pop < DEPTH_C);
    push_b          = (iec_cnt_q == '0);
    count_d         = count_after_pop + CW'(push_ok);
    rd_ptr_d        = rd_ptr_q + pop_n[PW-1:0];
    wr_ptr_d        = wr_ptr_q + PW'(push_ok);
    overflow_d      = overflow_q | (audio_sample_valid & ~push_ok);
    iec_cnt_d       = iec_cnt_q;
    if (push_ok) begin
      iec_cnt_d = (iec_cnt_q == IEC_LAST) ? '0 : iec_cnt_q + 1'b1;
    end
  end

  // Payload is rebuilt only on packet_enable and held for the whole slot.
  // Non-audio selections and unfilled audio slots carry zeros.
  always_comb begin
    pkt_type_d = pkt_type_q;
    samples_d  = samples_q;
    present_d  = present_q;
    b_d        = b_q;
    rd_idx     = '0;
    if (packet_enable) begin
      pkt_type_d = sel;
      samples_d  = '0;
      present_d  = '0;
      b_d        = '0;
      for (int k = 0; k < 4; k++) begin
        rd_idx = rd_ptr_q + PW'(k);
        if (CW'(k) < pop_n) begin
          samples_d[32*k +: 32] = fifo_word_q[rd_idx];
          present_d[k]          = 1'b1;
          b_d[k]                = fifo_b_q[rd_idx];
        end
      end
    end
  end

  always_ff @(posedge clk_pixel) begin
    if (reset) begin
      // Loading the live toggle level keeps reset release from looking
      // like a toggle.
      wrap_hist_q   <= clk_audio_counter_wrap;
      acr_pending_q <= 1'b0;
      avi_pending_q <= 1'b0;
      aif_pending_q <= 1'b0;
      rd_ptr_q      <= '0;
      wr_ptr_q      <= '0;
      count_q       <= '0;
      iec_cnt_q     <= '0;
      overflow_q    <= 1'b0;
      pkt_type_q    <= PT_NULL;
      samples_q     <= '0;
      present_q     <= '0;
      b_q           <= '0;
    end else begin
      wrap_hist_q   <= clk_audio_counter_wrap;
      acr_pending_q <= acr_pending_d;
      avi_pending_q <= avi_pending_d;
      aif_pending_q <= aif_pending_d;
      rd_ptr_q      <= rd_ptr_d;
      wr_ptr_q      <= wr_ptr_d;
      count_q       <= count_d;
      iec_cnt_q     <= iec_cnt_d;
      overflow_q    <= overflow_d;
      pkt_type_q    <= pkt_type_d;
      samples_q     <= samples_d;
      present_q     <= present_d;
      b_q           <= b_d;
    end
  end

  // Storage needs no reset: the pointers and count define what is valid.
  always_ff @(posedge clk_pixel) begin
    if (!reset && push_ok) begin
      fifo_word_q[wr_ptr_q] <= audio_sample_word;
      fifo_b_q[wr_ptr_q]    <= push_b;
    end
  end

  assign packet_type          = pkt_type_q;
  assign audio_samples        = samples_q;
  assign audio_sample_present = present_q;
  assign audio_sample_b       = b_q;
  assign audio_overflow       = overflow_q;

`ifdef HDMI_PACKET_SCHED_STATS_EN
  logic [15:0] stat_acr_q, stat_acr_d;
  logic [15:0] stat_audio_q, stat_audio_d;

  always_comb begin
    stat_acr_d   = stat_acr_q;
    stat_audio_d = stat_audio_q;
    if (packet_enable && (sel == PT_ACR) && (stat_acr_q != 16'hFFFF)) begin
      stat_acr_d = stat_acr_q + 16'd1;
    end
    if (packet_enable && (sel == PT_AUDIO) && (stat_audio_q != 16'hFFFF)) begin
      stat_audio_d = stat_audio_q + 16'd1;
    end
  end

  always_ff @(posedge clk_pixel) begin
    if (reset) begin
      stat_acr_q   <= '0;
      stat_audio_q <= '0;
    end else begin
      stat_acr_q   <= stat_acr_d;
      stat_audio_q <= stat_audio_d;
    end
  end

  assign stat_acr_count   = stat_acr_q;
  assign stat_audio_count = stat_audio_q;
`else
  assign stat_acr_count   = '0;
  assign stat_audio_count = '0;
`endif

endmodule

// File: tb/tb_hdmi_packet_scheduler.sv
// tb_hdmi_packet_scheduler
//
// Purpose:
//   Self-checking bench for hdmi_packet_scheduler. Inputs are driven on the
//   falling edge; outputs are compared on the falling edge after the rising
//   edge that consumed packet_enable. Expected slot contents are queued when
//   a slot is driven and popped by the output monitor.
//
// Build option:
//   HDMI_PACKET_SCHED_STATS_EN - selects the expected stat counter values.

module tb_hdmi_packet_scheduler;

  logic         clk;
  logic         reset;
  logic         wrap;
  logic         frame_start;
  logic         audio_sample_valid;
  logic [31:0]  audio_sample_word;
  logic         packet_enable;
  logic [7:0]   packet_type;
  logic [127:0] audio_samples;
  logic [3:0]   audio_sample_present;
  logic [3:0]   audio_sample_b;
  logic         audio_overflow;
  logic [15:0]  stat_acr_count;
  logic [15:0]  stat_audio_count;

`ifdef HDMI_PACKET_SCHED_STATS_EN
  localparam logic [15:0] EXP_ACR_STAT = 16'd3;
  localparam logic [15:0] EXP_AUD_STAT = 16'd5;
`else
  localparam logic [15:0] EXP_ACR_STAT = 16'd0;
  localparam logic [15:0] EXP_AUD_STAT = 16'd0;
`endif

  hdmi_packet_scheduler #(
    .AUDIO_FIFO_DEPTH(4),
    .IEC_BLOCK_LEN(192)
  ) dut (
    .clk_pixel              (clk),
    .reset                  (reset),
    .clk_audio_counter_wrap (wrap),
    .frame_start            (frame_start),
    .audio_sample_valid     (audio_sample_valid),
    .audio_sample_word      (audio_sample_word),
    .packet_enable          (packet_enable),
    .packet_type            (packet_type),
    .audio_samples          (audio_samples),
    .audio_sample_present   (audio_sample_present),
    .audio_sample_b         (audio_sample_b),
    .audio_overflow         (audio_overflow),
    .stat_acr_count         (stat_acr_count),
    .stat_audio_count       (stat_audio_count)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached got running want finished");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  // Expected slot record: {type[7:0], present[3:0], b[3:0], samples[127:0]}
  logic [143:0] exp_q[$];
  logic [31:0]  mq[$];      // words the FIFO should currently hold
  int           n_cmp = 0;
  int           n_bad = 0;
  int           b_total = 0;
  logic         slot_fired = 1'b0;

  always @(posedge clk) slot_fired <= packet_enable && !reset;

  always @(negedge clk) begin
    logic [143:0] act;
    logic [143:0] e;
    if (slot_fired) begin
      act = {packet_type, audio_sample_present, audio_sample_b, audio_samples};
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL slot_unexpected: got %h want no slot", act);
      end else begin
        e = exp_q.pop_front();
        if (act !== e) begin
          n_bad++;
          $display("FAIL slot_out: got %h want %h", act, e);
        end
      end
      b_total += $countones(audio_sample_b);
    end
  end

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic model_push(input logic [31:0] w);
    if (mq.size() < 4) mq.push_back(w);
  endtask

  task automatic push(input logic [31:0] w);
    audio_sample_valid = 1'b1;
    audio_sample_word  = w;
    model_push(w);
    cyc();
    audio_sample_valid = 1'b0;
  endtask

  task automatic toggle();
    wrap = ~wrap;
    cyc();
  endtask

  task automatic frame();
    frame_start = 1'b1;
    cyc();
    frame_start = 1'b0;
  endtask

  // One packet_enable pulse; optionally a same-cycle push and/or toggle.
  task automatic slot(input logic [7:0] t, input logic [3:0] p, input logic [3:0] b,
                      input logic do_push, input logic [31:0] w, input logic do_tog);
    logic [127:0] s;
    s = '0;
    for (int k = 0; k < 4; k++) begin
      if (p[k] && mq.size() > 0) s[32*k +: 32] = mq.pop_front();
    end
    exp_q.push_back({t, p, b, s});
    packet_enable = 1'b1;
    if (do_push) begin
      audio_sample_valid = 1'b1;
      audio_sample_word  = w;
      model_push(w);
    end
    if (do_tog) wrap = ~wrap;
    cyc();
    packet_enable      = 1'b0;
    audio_sample_valid = 1'b0;
  endtask

  task automatic do_reset(input int cycles);
    reset = 1'b1;
    for (int i = 0; i < cycles; i++) cyc();
    mq.delete();
    reset = 1'b0;
  endtask

  // ---------------- vector table ----------------
  typedef struct packed {
    logic        tog;
    logic        frm;
    logic [2:0]  nsamp;
    logic [31:0] base;
    logic [7:0]  t;
    logic [3:0]  p;
    logic [3:0]  b;
    logic        ovf;
  } vec_t;

  vec_t tbl[11];

  initial begin
    reset              = 1'b1;
    wrap               = 1'b1;
    frame_start        = 1'b0;
    audio_sample_valid = 1'b0;
    audio_sample_word  = '0;
    packet_enable      = 1'b0;

    //          tog   frm   n     base          type   pres   b      ovf
    tbl[0]  = '{1'b0, 1'b0, 3'd0, 32'h00000000, 8'h00, 4'h0, 4'h0, 1'b0};
    tbl[1]  = '{1'b1, 1'b0, 3'd2, 32'h11112222, 8'h01, 4'h0, 4'h0, 1'b0};
    tbl[2]  = '{1'b0, 1'b0, 3'd0, 32'h00000000, 8'h02, 4'h3, 4'h1, 1'b0};
    tbl[3]  = '{1'b0, 1'b0, 3'd6, 32'h01010101, 8'h02, 4'hF, 4'h0, 1'b1};
    tbl[4]  = '{1'b0, 1'b0, 3'd0, 32'h00000000, 8'h00, 4'h0, 4'h0, 1'b1};
    tbl[5]  = '{1'b0, 1'b0, 3'd0, 32'h00000000, 8'h00, 4'h0, 4'h0, 1'b1};
    tbl[6]  = '{1'b1, 1'b1, 3'd1, 32'h5A5A0000, 8'h01, 4'h0, 4'h0, 1'b1};
    tbl[7]  = '{1'b0, 1'b0, 3'd0, 32'h00000000, 8'h02, 4'h1, 4'h0, 1'b1};
    tbl[8]  = '{1'b0, 1'b0, 3'd0, 32'h00000000, 8'h82, 4'h0, 4'h0, 1'b1};
    tbl[9]  = '{1'b0, 1'b0, 3'd0, 32'h00000000, 8'h84, 4'h0, 4'h0, 1'b1};
    tbl[10] = '{1'b0, 1'b0, 3'd0, 32'h00000000, 8'h00, 4'h0, 4'h0, 1'b1};

    // Reset state, with the toggle input held high.
    for (int i = 0; i < 3; i++) cyc();
    chk("rst_type",    packet_type,          0);
    chk("rst_samples", audio_samples,        0);
    chk("rst_present", audio_sample_present, 0);
    chk("rst_b",       audio_sample_b,       0);
    chk("rst_ovf",     audio_overflow,       0);
    chk("rst_stat_acr", stat_acr_count,      0);
    chk("rst_stat_aud", stat_audio_count,    0);
    mq.delete();
    reset = 1'b0;

    // Table: main function, overflow, priority order.
    for (int r = 0; r < 11; r++) begin
      if (tbl[r].tog) toggle();
      if (tbl[r].frm) frame();
      for (int i = 0; i < int'(tbl[r].nsamp); i++)
        push(tbl[r].base + 32'(i) * 32'h22222222);
      slot(tbl[r].t, tbl[r].p, tbl[r].b, 1'b0, 32'h0, 1'b0);
      chk($sformatf("tbl%0d_ovf", r), audio_overflow, tbl[r].ovf);
    end

    // A toggle in the same cycle as packet_enable is held for the next slot.
    slot(8'h00, 4'h0, 4'h0, 1'b0, 32'h0, 1'b1);
    slot(8'h01, 4'h0, 4'h0, 1'b0, 32'h0, 1'b0);
    slot(8'h00, 4'h0, 4'h0, 1'b0, 32'h0, 1'b0);

    // Reset in the middle of a slot clears outputs and discards samples.
    push(32'hCAFE0001);
    push(32'hCAFE0002);
    slot(8'h02, 4'h3, 4'h0, 1'b0, 32'h0, 1'b0);
    cyc();
    cyc();
    push(32'hCAFE0003);
    push(32'hCAFE0004);
    reset = 1'b1;
    cyc();
    chk("midrst_type",    packet_type,          0);
    chk("midrst_samples", audio_samples,        0);
    chk("midrst_present", audio_sample_present, 0);
    chk("midrst_ovf",     audio_overflow,       0);
    mq.delete();
    reset = 1'b0;
    slot(8'h00, 4'h0, 4'h0, 1'b0, 32'h0, 1'b0);

    // Full FIFO popped and pushed in the same cycle: pop first, no overflow.
    for (int i = 0; i < 4; i++) push(32'hB0000000 + 32'(i));
    slot(8'h02, 4'hF, 4'h1, 1'b1, 32'hDEADBEEF, 1'b0);
    slot(8'h02, 4'h1, 4'h0, 1'b0, 32'h0, 1'b0);
    chk("popush_ovf", audio_overflow, 0);

    // 200 samples streamed; B expected only on samples #0 and #192.
    do_reset(2);
    b_total = 0;
    for (int i = 0; i < 200; i++) begin
      push($urandom);
      if (i % 4 == 3)
        slot(8'h02, 4'hF, ((i / 4) == 0 || (i / 4) == 48) ? 4'h1 : 4'h0, 1'b0, 32'h0, 1'b0);
    end
    cyc();
    chk("iec_b_total", b_total, 2);
    chk("iec_ovf", audio_overflow, 0);

    // Stats: 3 ACR and 5 audio packets after reset.
    do_reset(2);
    for (int i = 0; i < 3; i++) begin
      toggle();
      slot(8'h01, 4'h0, 4'h0, 1'b0, 32'h0, 1'b0);
    end
    for (int i = 0; i < 5; i++) begin
      push(32'(($urandom_range(0, 65535) << 16) | i));
      slot(8'h02, 4'h1, (i == 0) ? 4'h1 : 4'h0, 1'b0, 32'h0, 1'b0);
    end
    cyc();
    chk("stat_acr",   stat_acr_count,   EXP_ACR_STAT);
    chk("stat_audio", stat_audio_count, EXP_AUD_STAT);

    cyc();
    cyc();
    chk("exp_q_drained", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
